// File: rtl/seq_match_window_counter.sv
// Counts qualified detector match pulses over back-to-back windows of WINDOW_LEN
// cycles and publishes each count on a valid/ready port with a threshold alarm.
// Build option: define MATCH_EDGE_QUAL_EN to count only rising edges of det_in.
module seq_match_window_counter #(
    parameter int CNT_W      = 8,
    parameter int WINDOW_LEN = 64,
    parameter int THRESH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_in,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] live_cnt,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_partial,
    output logic             overrun,
    output logic             alarm
);

    localparam int                CYC_W     = $clog2(WINDOW_LEN);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    // Thresholds beyond the counter range can never be reached; clamp so the
    // compare stays in CNT_W+1 bits without truncating the parameter.
    localparam int                THR_CLAMP = (THRESH < 0) ? 0 :
                                              (THRESH > (1 << CNT_W)) ? (1 << CNT_W) : THRESH;
    localparam logic [CNT_W:0]    THR_EXT   = THR_CLAMP[CNT_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             partial_q, partial_d;
    logic             overrun_q, overrun_d;
    logic             alarm_q, alarm_d;

    logic             qual;
    logic [CNT_W:0]   live_inc;
    logic [CNT_W-1:0] sat_cnt;
    logic             publish;

`ifdef MATCH_EDGE_QUAL_EN
    logic det_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_q <= 1'b0;
        end else if (clear) begin
            det_q <= 1'b0;
        end else begin
            det_q <= det_in;
        end
    end

    assign qual = det_in & ~det_q;
`else
    assign qual = det_in;
`endif

    // Count including this cycle's match, pinned at the counter maximum.
    assign live_inc = {1'b0, live_q} + (CNT_W + 1)'(qual);
    assign sat_cnt  = live_inc[CNT_W] ? CNT_MAX : live_inc[CNT_W-1:0];

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        live_d    = live_q;
        cyc_d     = cyc_q;
        result_d  = result_q;
        valid_d   = valid_q;
        partial_d = partial_q;
        overrun_d = overrun_q;
        alarm_d   = alarm_q;
        publish   = 1'b0;

        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                live_d = '0;
                cyc_d  = '0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable || (cyc_q == CYC_LAST)) begin
                    publish = 1'b1;
                    live_d  = '0;
                    cyc_d   = '0;
                    state_d = enable ? ST_RUN : ST_DRAIN;
                end else begin
                    live_d = sat_cnt;
                    cyc_d  = cyc_q + CYC_W'(1);
                end
            end
            ST_DRAIN: begin
                live_d  = '0;
                cyc_d   = '0;
                state_d = enable ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A publish overrides any accept at the same edge; overrun only when
        // the previous result was still pending and not taken this cycle.
        if (publish) begin
            result_d  = sat_cnt;
            partial_d = ~enable;
            valid_d   = 1'b1;
            alarm_d   = ({1'b0, sat_cnt} >= THR_EXT);
            overrun_d = overrun_q | (valid_q & ~result_ready);
        end

        if (clear) begin
            state_d   = ST_IDLE;
            live_d    = '0;
            cyc_d     = '0;
            result_d  = '0;
            valid_d   = 1'b0;
            partial_d = 1'b0;
            overrun_d = 1'b0;
            alarm_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            live_q    <= '0;
            cyc_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            overrun_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            cyc_q     <= cyc_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
            overrun_q <= overrun_d;
            alarm_q   <= alarm_d;
        end
    end

    assign live_cnt       = live_q;
    assign result         = result_q;
    assign result_valid   = valid_q;
    assign result_partial = partial_q;
    assign overrun        = overrun_q;
    assign alarm          = alarm_q;

endmodule
